// File: rtl/ifetch_seq_if.sv
// Instruction-memory read port shared by the fetch sequencer and the memory model.
interface ifetch_seq_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_rdy;
   logic [15:0] mem_data;

   modport master (output mem_addr, output mem_rd, input mem_rdy, input mem_data);
   modport slave  (input mem_addr, input mem_rd, output mem_rdy, output mem_data);
endinterface

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: IDLE -> REQ -> LOAD -> WAIT.
// Optional memory timeout is enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_seq #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          run,
   input  logic          next_req,
   input  logic          pc_load,
   input  logic [15:0]   pc_val,
   output logic [15:0]   ir_data,
   output logic          en_ir,
   output logic          busy,
   output logic          fetch_err,
   ifetch_seq_if.master  mem
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOAD, S_WAIT} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc;
   logic        timeout;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (run) state_nxt = S_REQ;
         S_REQ:   if (mem.mem_rdy) state_nxt = S_LOAD;
                  else if (timeout) state_nxt = S_IDLE;
         S_LOAD:  state_nxt = S_WAIT;
         S_WAIT:  if (next_req) state_nxt = run ? S_REQ : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_addr = pc;
      mem.mem_rd   = (state == S_REQ);
      en_ir        = (state == S_LOAD);
      busy         = (state != S_IDLE);
   end

   // pc_load is honoured only in IDLE and, together with next_req, in WAIT.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pc      <= RESET_PC;
         ir_data <= 16'h0000;
      end else begin
         case (state)
            S_IDLE:  if (pc_load) pc <= pc_val;
            S_REQ:   if (mem.mem_rdy) ir_data <= mem.mem_data;
            S_LOAD:  pc <= pc + 16'd1;
            S_WAIT:  if (next_req && pc_load) pc <= pc_val;
            default: ;
         endcase
      end
   end

`ifdef IFETCH_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // The 255th consecutive stalled REQ cycle is the one that trips the timeout.
   assign timeout = (state == S_REQ) && !mem.mem_rdy && (wait_cnt == 8'd254);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wait_cnt  <= 8'd0;
         fetch_err <= 1'b0;
      end else begin
         fetch_err <= timeout;
         if ((state == S_REQ) && !mem.mem_rdy && !timeout) wait_cnt <= wait_cnt + 8'd1;
         else                                              wait_cnt <= 8'd0;
      end
   end
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_ifetch_seq;

   localparam logic [15:0] RST_PC = 16'h0000;
`ifdef IFETCH_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic        clk;
   logic        clr;
   logic        run;
   logic        next_req;
   logic        pc_load;
   logic [15:0] pc_val;
   logic [15:0] ir_data;
   logic        en_ir;
   logic        busy;
   logic        fetch_err;

   ifetch_seq_if bus ();

   ifetch_seq #(.RESET_PC(RST_PC)) dut (
      .clk       (clk),
      .clr       (clr),
      .run       (run),
      .next_req  (next_req),
      .pc_load   (pc_load),
      .pc_val    (pc_val),
      .ir_data   (ir_data),
      .en_ir     (en_ir),
      .busy      (busy),
      .fetch_err (fetch_err),
      .mem       (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a fetch is "requesting" until data arrives, then "strobing" one cycle,
   // then "holding" until the execute stage asks for more.
   logic [15:0] m_pc, m_ir;
   bit          m_requesting, m_strobing, m_holding, m_err;
   int          m_stall;

   task automatic model_reset();
      m_pc = RST_PC; m_ir = 16'h0000;
      m_requesting = 0; m_strobing = 0; m_holding = 0; m_err = 0; m_stall = 0;
   endtask

   task automatic model_edge();
      if (!clr) begin
         model_reset();
         return;
      end
      m_err = 0;
      if (m_requesting) begin
         if (bus.mem_rdy) begin
            m_ir = bus.mem_data;
            m_requesting = 0; m_strobing = 1;
         end else if (TIMEOUT_ON) begin
            m_stall++;
            if (m_stall == 255) begin
               m_err = 1; m_requesting = 0; m_stall = 0;
            end
         end
      end else if (m_strobing) begin
         m_pc = m_pc + 16'd1;
         m_strobing = 0; m_holding = 1;
      end else if (m_holding) begin
         if (next_req) begin
            if (pc_load) m_pc = pc_val;
            m_holding = 0;
            if (run) begin m_requesting = 1; m_stall = 0; end
         end
      end else begin
         if (pc_load) m_pc = pc_val;
         if (run) begin m_requesting = 1; m_stall = 0; end
      end
   endtask

   task automatic compare();
      check("mem_addr", bus.mem_addr, m_pc);
      check("mem_rd", {15'd0, bus.mem_rd}, {15'd0, m_requesting});
      check("en_ir", {15'd0, en_ir}, {15'd0, m_strobing});
      check("ir_data", ir_data, m_ir);
      check("busy", {15'd0, busy}, {15'd0, (m_requesting | m_strobing | m_holding)});
      check("fetch_err", {15'd0, fetch_err}, {15'd0, m_err});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic drive(input logic r, input logic rdy, input logic [15:0] d,
                        input logic nr, input logic pl, input logic [15:0] pv);
      run = r; bus.mem_rdy = rdy; bus.mem_data = d;
      next_req = nr; pc_load = pl; pc_val = pv;
   endtask

   initial begin
      int n_rd, n_ir, n_err, n;
      clr = 1'b0;
      drive(0, 0, 16'h0000, 0, 0, 16'h0000);
      model_reset();
      @(negedge clk);
      check("reset_addr", bus.mem_addr, RST_PC);
      check("reset_busy", {15'd0, busy}, 16'd0);
      check("reset_ir", ir_data, 16'h0000);
      step();
      clr = 1'b1;

      // Basic fetch from reset PC with ready memory
      drive(1, 1, 16'hA5A5, 0, 0, 16'h0000);
      step();
      check("f1_addr", bus.mem_addr, 16'h0000);
      check("f1_rd", {15'd0, bus.mem_rd}, 16'd1);
      step();
      check("f1_en_ir", {15'd0, en_ir}, 16'd1);
      check("f1_ir", ir_data, 16'hA5A5);
      step();
      check("f1_wait_en_ir", {15'd0, en_ir}, 16'd0);
      check("f1_wait_rd", {15'd0, bus.mem_rd}, 16'd0);
      next_req = 1'b1;
      step();
      check("f2_addr", bus.mem_addr, 16'h0001);
      check("f2_rd", {15'd0, bus.mem_rd}, 16'd1);
      next_req = 1'b0;
      step();
      step();

      // Branch in WAIT, then pc_load ignored during REQ/LOAD
      drive(1, 1, 16'h1111, 1, 1, 16'h1234);
      step();
      check("br_addr", bus.mem_addr, 16'h1234);
      drive(1, 0, 16'h2222, 0, 1, 16'hBEEF);
      step();
      check("br_req_ignore", bus.mem_addr, 16'h1234);
      bus.mem_rdy = 1'b1;
      step();
      step();
      check("br_inc", bus.mem_addr, 16'h1235);
      pc_load = 1'b0;

      // Stalled memory: 10 cycles not ready, then ready
      drive(1, 0, 16'h3C3C, 1, 0, 16'h0000);
      step();
      next_req = 1'b0;
      n_rd = 0; n_err = 0;
      for (int i = 0; i < 10; i++) begin
         n_rd += int'(bus.mem_rd); n_err += int'(fetch_err);
         step();
      end
      bus.mem_rdy = 1'b1;
      n_rd += int'(bus.mem_rd);
      step();
      n_ir = 0;
      for (int i = 0; i < 4; i++) begin
         n_ir += int'(en_ir); n_err += int'(fetch_err);
         step();
      end
      check("stall_rd_cycles", 16'(n_rd), 16'd11);
      check("stall_en_ir_pulses", 16'(n_ir), 16'd1);
      check("stall_fetch_err", 16'(n_err), 16'd0);

      // PC wrap from 16'hFFFF
      drive(0, 1, 16'h7777, 1, 0, 16'h0000);
      step();
      drive(1, 1, 16'h7777, 0, 1, 16'hFFFF);
      step();
      check("wrap_addr", bus.mem_addr, 16'hFFFF);
      pc_load = 1'b0;
      step();
      step();
      check("wrap_pc", bus.mem_addr, 16'h0000);

      // Asynchronous reset in the middle of REQ
      drive(1, 0, 16'h9999, 1, 0, 16'h0000);
      step();
      next_req = 1'b0;
      check("ar_rd_before", {15'd0, bus.mem_rd}, 16'd1);
      #2 clr = 1'b0;
      #1;
      check("ar_rd", {15'd0, bus.mem_rd}, 16'd0);
      check("ar_busy", {15'd0, busy}, 16'd0);
      check("ar_en_ir", {15'd0, en_ir}, 16'd0);
      check("ar_addr", bus.mem_addr, RST_PC);
      check("ar_ir", ir_data, 16'h0000);
      check("ar_err", {15'd0, fetch_err}, 16'd0);
      model_reset();
      step();
      clr = 1'b1;

`ifdef IFETCH_TIMEOUT_EN
      // Memory never answers: timeout after 255 REQ cycles
      drive(1, 0, 16'h0000, 0, 1, 16'h4000);
      step();
      pc_load = 1'b0;
      n = 0;
      while (bus.mem_rd && n < 300) begin
         n++;
         step();
      end
      check("tmo_req_cycles", 16'(n), 16'd255);
      check("tmo_err", {15'd0, fetch_err}, 16'd1);
      check("tmo_busy", {15'd0, busy}, 16'd0);
      check("tmo_pc", bus.mem_addr, 16'h4000);
      run = 1'b0;
      step();
      check("tmo_err_pulse", {15'd0, fetch_err}, 16'd0);
`else
      n = 0;
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 1)),
               16'($urandom), logic'($urandom_range(0, 3) == 0),
               logic'($urandom_range(0, 2) == 0), 16'($urandom));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
